// File: rtl/stack_call_ctrl.sv
// stack_call_ctrl: call/return controller for an attached LIFO of return
// addresses.
//
// Ports:
//   clock, reset        single clock, asynchronous active-high reset
//   call, ret           level-held requests, released after call_ack/ret_ack
//   pc_next             return address saved on call
//   clr_err             clears overflow/underflow and reloads hwm with depth_cnt
//   lifo_q              registered LIFO read data
//   lifo_empty/full     registered LIFO status
//   lifo_data           LIFO write data
//   lifo_push/pop       one-cycle LIFO strobes
//   call_ack, ret_ack   one-cycle accept pulses
//   ret_valid, ret_addr popped return address and its qualifier
//   busy                FSM not in IDLE
//   overflow/underflow  sticky error flags
//   depth_cnt, hwm      mirrored occupancy and its high-water mark
module stack_call_ctrl #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             call,
  input  logic             ret,
  input  logic [15:0]      pc_next,
  input  logic             clr_err,
  input  logic [15:0]      lifo_q,
  input  logic             lifo_empty,
  input  logic             lifo_full,
  output logic [15:0]      lifo_data,
  output logic             lifo_push,
  output logic             lifo_pop,
  output logic             call_ack,
  output logic             ret_ack,
  output logic             ret_valid,
  output logic [15:0]      ret_addr,
  output logic             busy,
  output logic             overflow,
  output logic             underflow,
  output logic [CNT_W-1:0] depth_cnt,
  output logic [CNT_W-1:0] hwm
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] PUSH = 3'd1;
  localparam logic [2:0] POP  = 3'd2;
  localparam logic [2:0] WAIT = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [2:0]  state;
  logic [2:0]  state_next;
  logic [15:0] ret_hold;
  logic        quiet;
  logic        take_call;
  logic        take_ret;

  always_comb begin
    // A request is not taken while an ack is still visible (the requester
    // has not yet released it) or while a push/pop strobe is out, because
    // the registered LIFO flags do not yet reflect that operation.
    quiet      = !(call_ack | ret_ack | lifo_push | lifo_pop);
    take_call  = (state == IDLE) && quiet && call;
    take_ret   = (state == IDLE) && quiet && ret && !call;
    state_next = state;
    case (state)
      IDLE: begin
        if (take_call && !lifo_full) state_next = PUSH;
        else if (take_ret)           state_next = lifo_empty ? DONE : POP;
      end
      PUSH:    state_next = IDLE;
      POP:     state_next = WAIT;
      WAIT:    state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      call_ack  <= 1'b0;
      ret_ack   <= 1'b0;
      lifo_push <= 1'b0;
      lifo_pop  <= 1'b0;
      lifo_data <= '0;
      ret_hold  <= '0;
      ret_valid <= 1'b0;
      ret_addr  <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      depth_cnt <= '0;
      hwm       <= '0;
    end else begin
      state     <= state_next;
      busy      <= (state_next != IDLE);
      call_ack  <= take_call;
      ret_ack   <= take_ret;
      lifo_push <= (state == PUSH);
      // Pop strobe covers the POP cycle so lifo_q is valid during WAIT.
      lifo_pop  <= take_ret && !lifo_empty;
      if (take_call && !lifo_full) lifo_data <= pc_next;
      if (take_ret && lifo_empty)  ret_hold <= '0;
      if (state == WAIT)           ret_hold <= lifo_q;
      ret_valid <= (state == DONE);
      if (state == DONE)           ret_addr <= ret_hold;
      // A new error wins over a simultaneous clear.
      overflow  <= (take_call && lifo_full) || (overflow && !clr_err);
      underflow <= (take_ret && lifo_empty) || (underflow && !clr_err);
      if (lifo_push && depth_cnt != DEPTH_C)
        depth_cnt <= depth_cnt + CNT_W'(1);
      else if (lifo_pop && depth_cnt != '0)
        depth_cnt <= depth_cnt - CNT_W'(1);
      if (clr_err)              hwm <= depth_cnt;
      else if (depth_cnt > hwm) hwm <= depth_cnt;
    end
  end

endmodule

// File: tb/tb_stack_call_ctrl.sv
// tb_stack_call_ctrl: directed bench for stack_call_ctrl with a behavioural
// LIFO attached; expected push data and return addresses are queued when a
// request is driven and compared when the DUT strobes them.
module tb_stack_call_ctrl;
  localparam int DEPTH = 16;
  localparam int CNT_W = 5;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             call = 1'b0;
  logic             ret = 1'b0;
  logic [15:0]      pc_next = '0;
  logic             clr_err = 1'b0;
  logic [15:0]      lifo_q;
  logic             lifo_empty;
  logic             lifo_full;
  logic [15:0]      lifo_data;
  logic             lifo_push;
  logic             lifo_pop;
  logic             call_ack;
  logic             ret_ack;
  logic             ret_valid;
  logic [15:0]      ret_addr;
  logic             busy;
  logic             overflow;
  logic             underflow;
  logic [CNT_W-1:0] depth_cnt;
  logic [CNT_W-1:0] hwm;

  always #5 clock = ~clock;

  stack_call_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .call(call), .ret(ret), .pc_next(pc_next),
    .clr_err(clr_err), .lifo_q(lifo_q), .lifo_empty(lifo_empty),
    .lifo_full(lifo_full), .lifo_data(lifo_data), .lifo_push(lifo_push),
    .lifo_pop(lifo_pop), .call_ack(call_ack), .ret_ack(ret_ack),
    .ret_valid(ret_valid), .ret_addr(ret_addr), .busy(busy),
    .overflow(overflow), .underflow(underflow), .depth_cnt(depth_cnt),
    .hwm(hwm)
  );

  // Behavioural LIFO: registered read data, flags derived from a register.
  logic [15:0] mem [DEPTH];
  int unsigned sp;
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      sp     <= 0;
      lifo_q <= '0;
    end else if (lifo_push && sp < DEPTH) begin
      mem[sp] <= lifo_data;
      sp      <= sp + 1;
    end else if (lifo_pop && sp > 0) begin
      lifo_q <= mem[sp-1];
      sp     <= sp - 1;
    end
  end
  assign lifo_empty = (sp == 0);
  assign lifo_full  = (sp == DEPTH);

  typedef struct {
    logic [15:0] addr;
    int          lat;
  } ret_exp_t;

  logic [15:0] push_q [$];
  ret_exp_t    ret_q [$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor, sampled on the falling edge.
  int          cyc = 0;
  int          ack_cyc = 0;
  int          pops = 0;
  int          rvalids = 0;
  logic [15:0] exp_data;
  ret_exp_t    exp_ret;
  always @(negedge clock) begin
    cyc++;
    if (!reset) begin
      if (lifo_push || lifo_pop) check("push_pop_excl", {31'b0, lifo_push & lifo_pop}, 0);
      if (lifo_pop) pops++;
      if (ret_ack) ack_cyc = cyc;
      if (lifo_push) begin
        if (push_q.size() == 0) check("unexpected_push", 1, 0);
        else begin
          exp_data = push_q.pop_front();
          check("lifo_data", {16'b0, lifo_data}, {16'b0, exp_data});
        end
      end
      if (ret_valid) begin
        rvalids++;
        if (ret_q.size() == 0) check("unexpected_ret_valid", 1, 0);
        else begin
          exp_ret = ret_q.pop_front();
          check("ret_addr", {16'b0, ret_addr}, {16'b0, exp_ret.addr});
          if (exp_ret.lat != 0) check("ret_latency", cyc - ack_cyc, exp_ret.lat);
        end
      end
    end
  end

  task automatic do_call(input logic [15:0] a, input bit exp_push);
    bit got;
    got = 0;
    @(posedge clock); #1;
    call = 1'b1;
    pc_next = a;
    if (exp_push) push_q.push_back(a);
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clock);
      if (call_ack) got = 1;
    end
    check("call_ack", {31'b0, got}, 1);
    @(posedge clock); #1;
    call = 1'b0;
    if (exp_push) begin
      @(negedge clock);
      check("push_one_cycle_after_ack", {31'b0, lifo_push}, 1);
    end
    repeat (3) @(negedge clock);
  endtask

  task automatic wait_ret_ack();
    bit got;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clock);
      if (ret_ack) got = 1;
    end
    check("ret_ack", {31'b0, got}, 1);
  endtask

  task automatic do_ret(input logic [15:0] a, input int lat);
    @(posedge clock); #1;
    ret = 1'b1;
    ret_q.push_back('{a, lat});
    wait_ret_ack();
    @(posedge clock); #1;
    ret = 1'b0;
    repeat (6) @(negedge clock);
  endtask

  task automatic pulse_clr();
    @(posedge clock); #1;
    clr_err = 1'b1;
    @(posedge clock); #1;
    clr_err = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  int pops_before;
  int rv_before;
  bit got_call;

  initial begin
    // Reset values
    #1 reset = 1'b1;
    repeat (2) @(negedge clock);
    check("rst_lifo_push", {31'b0, lifo_push}, 0);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_flags", {28'b0, call_ack, ret_ack, overflow, underflow}, 0);
    check("rst_depth_hwm", {22'b0, depth_cnt, hwm}, 0);
    check("rst_data_addr", {lifo_data, ret_addr}, 0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // Single call
    do_call(16'h1234, 1);
    check("depth_after_call", depth_cnt, 1);
    check("hwm_after_call", hwm, 1);
    do_ret(16'h1234, 3);
    check("depth_after_ret", depth_cnt, 0);

    // Two calls, two returns in LIFO order
    do_call(16'hA001, 1);
    do_call(16'hA002, 1);
    check("depth_two", depth_cnt, 2);
    do_ret(16'hA002, 3);
    do_ret(16'hA001, 3);
    check("depth_back_zero", depth_cnt, 0);
    check("hwm_two", hwm, 2);
    check("ret_addr_held", {16'b0, ret_addr}, 32'hA001);

    // Return on empty stack
    pops_before = pops;
    do_ret(16'h0000, 0);
    check("underflow_no_pop", pops, pops_before);
    check("underflow_set", {31'b0, underflow}, 1);
    pulse_clr();
    check("underflow_cleared", {31'b0, underflow}, 0);

    // Fill to capacity, then overflow
    for (int i = 0; i < DEPTH; i++) do_call(16'hB000 + 16'(i), 1);
    check("depth_full", depth_cnt, DEPTH);
    do_call(16'hBFFF, 0);
    check("overflow_set", {31'b0, overflow}, 1);
    check("depth_saturated", depth_cnt, DEPTH);
    pulse_clr();
    check("overflow_cleared", {31'b0, overflow}, 0);
    repeat (2) @(negedge clock);

    // Clear coinciding with a new overflow: the flag must end up set
    @(posedge clock); #1;
    call = 1'b1;
    clr_err = 1'b1;
    pc_next = 16'hBEEF;
    @(posedge clock); #1;
    clr_err = 1'b0;
    @(negedge clock);
    check("ovf_call_ack", {31'b0, call_ack}, 1);
    check("ovf_wins_over_clr", {31'b0, overflow}, 1);
    @(posedge clock); #1;
    call = 1'b0;
    pulse_clr();
    repeat (2) @(negedge clock);

    for (int i = DEPTH - 1; i >= 0; i--) do_ret(16'hB000 + 16'(i), 3);
    check("depth_drained", depth_cnt, 0);
    check("hwm_full", hwm, DEPTH);
    pulse_clr();
    @(negedge clock);
    check("hwm_loaded_by_clr", hwm, 0);

    // call and ret together: call first, ret afterwards returns pc_next
    @(posedge clock); #1;
    call = 1'b1;
    ret = 1'b1;
    pc_next = 16'hC0DE;
    push_q.push_back(16'hC0DE);
    ret_q.push_back('{16'hC0DE, 3});
    got_call = 0;
    for (int i = 0; i < 20 && !got_call; i++) begin
      @(negedge clock);
      if (call_ack) got_call = 1;
    end
    check("both_call_ack", {31'b0, got_call}, 1);
    check("both_no_ret_ack", {31'b0, ret_ack}, 0);
    @(posedge clock); #1;
    call = 1'b0;
    wait_ret_ack();
    @(posedge clock); #1;
    ret = 1'b0;
    repeat (6) @(negedge clock);
    check("both_depth_zero", depth_cnt, 0);

    // Reset in WAIT aborts the return
    do_call(16'hD00D, 1);
    @(posedge clock); #1;
    ret = 1'b1;
    wait_ret_ack();
    rv_before = rvalids;
    @(posedge clock); #2;
    ret = 1'b0;
    reset = 1'b1;
    #1;
    check("abort_busy", {31'b0, busy}, 0);
    check("abort_lifo_data", {16'b0, lifo_data}, 0);
    check("abort_ret_addr", {16'b0, ret_addr}, 0);
    check("abort_depth_hwm", {22'b0, depth_cnt, hwm}, 0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (8) @(negedge clock);
    check("abort_no_ret_valid", rvalids, rv_before);

    check("push_q_drained", push_q.size(), 0);
    check("ret_q_drained", ret_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
